button_select_ctrl: RTL and testbench



---
 rtl/channel_strip_pkg.sv | 19 +
 rtl/button_sync.sv | 21 ++
 rtl/button_select_ctrl.sv | 96 +++++++++
 tb/tb_button_select_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/channel_strip_pkg.sv
// channel_strip_pkg: shared states, defaults and button map for the channel-strip front panel
package channel_strip_pkg;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, APPLY, WAIT_ACK, WAIT_RELEASE} ctrl_state_t;
  localparam int BTN_W = 16;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] FREQ_DEFAULT = 3'd5;
  localparam logic [SEL_W-1:0] LP_DEFAULT = 3'd0;
  localparam logic [SEL_W-1:0] HP_DEFAULT = 3'd0;
  localparam int FREQ_BTN_BASE = 0;
  localparam int LP_BTN_BASE = 8;
  localparam int HP_BTN_BASE = 12;
  localparam logic [BTN_W-1:0] ALL_RELEASED = '1;
  function automatic logic [3:0] low_index(input logic [BTN_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int k = 0; k < BTN_W; k++) if (!v[k]) idx = 4'(k);
    return idx;
  endfunction
endpackage

// File: rtl/button_sync.sv
// button_sync: two-flop synchroniser whose flops reset to all-ones (buttons released)
module button_sync #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  // shift raw inputs through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '1;
      q <= '1;
    end else begin
      s1 <= d;
      q <= s1;
    end
  end
endmodule

// File: rtl/button_select_ctrl.sv
// button_select_ctrl: debounces panel buttons, decodes one press and hands the new selection to the coefficient loader
module button_select_ctrl
  import channel_strip_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BTN_W-1:0] buttons,
  output logic [SEL_W-1:0] freqSelect,
  output logic [SEL_W-1:0] lowpassSelect,
  output logic [SEL_W-1:0] highpassSelect,
  output logic             cfgValid,
  input  logic             cfgReady
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  ctrl_state_t state, state_n;
  logic [BTN_W-1:0] sv, pv, pv_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] freq_n, lp_n, hp_n;
  logic valid_n, changed;
  logic [3:0] idx;
  button_sync #(.W(BTN_W)) u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .d(buttons),
    .q(sv)
  );
  assign idx = low_index(pv);
  // register FSM state, latched pattern, counter, selections and handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      pv <= ALL_RELEASED;
      cnt <= '0;
      freqSelect <= FREQ_DEFAULT;
      lowpassSelect <= LP_DEFAULT;
      highpassSelect <= HP_DEFAULT;
      cfgValid <= 1'b0;
    end else begin
      state <= state_n;
      pv <= pv_n;
      cnt <= cnt_n;
      freqSelect <= freq_n;
      lowpassSelect <= lp_n;
      highpassSelect <= hp_n;
      cfgValid <= valid_n;
    end
  end
  // next-state, decode and handshake sequencing; counter clears on every state change
  always_comb begin
    state_n = state;
    pv_n = pv;
    cnt_n = cnt;
    freq_n = freqSelect;
    lp_n = lowpassSelect;
    hp_n = highpassSelect;
    valid_n = cfgValid;
    changed = 1'b0;
    case (state)
      IDLE: if (sv != ALL_RELEASED) begin
        pv_n = sv;
        state_n = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (sv != pv) state_n = IDLE;
        else if (cnt == LAST) state_n = APPLY;
        else cnt_n = cnt + 1'b1;
      end
      APPLY: begin
        if ($countones(~pv) > 1) begin
          freq_n = FREQ_DEFAULT;
          lp_n = LP_DEFAULT;
          hp_n = HP_DEFAULT;
        end else if (int'(idx) < LP_BTN_BASE) freq_n = SEL_W'(int'(idx) - FREQ_BTN_BASE);
        else if (int'(idx) < HP_BTN_BASE) lp_n = {1'b0, 2'(int'(idx) - LP_BTN_BASE)};
        else hp_n = {1'b0, 2'(int'(idx) - HP_BTN_BASE)};
        changed = {freq_n, lp_n, hp_n} != {freqSelect, lowpassSelect, highpassSelect};
        valid_n = changed;
        state_n = changed ? WAIT_ACK : WAIT_RELEASE;
      end
      WAIT_ACK: if (cfgReady) begin
        valid_n = 1'b0;
        state_n = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (sv != ALL_RELEASED) cnt_n = '0;
        else if (cnt == LAST) state_n = IDLE;
        else cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end
endmodule

// File: tb/tb_button_select_ctrl.sv
// tb_button_select_ctrl: directed checks of debounce, decode, chord reset and handshake
module tb_button_select_ctrl;
  import channel_strip_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] buttons = 16'hFFFF;
  logic cfgReady = 1'b0;
  logic [2:0] freqSelect, lowpassSelect, highpassSelect;
  logic cfgValid;
  int checks = 0;
  int failures = 0;
  int n;
  button_select_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .buttons(buttons),
    .freqSelect(freqSelect),
    .lowpassSelect(lowpassSelect),
    .highpassSelect(highpassSelect),
    .cfgValid(cfgValid),
    .cfgReady(cfgReady)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic watch(input int k, output int cnt);
    cnt = 0;
    repeat (k) begin
      tick(1);
      if (cfgValid) cnt++;
    end
  endtask
  task automatic check_sel(input string tag, input logic [2:0] f, input logic [2:0] l, input logic [2:0] h);
    check({tag, "_freq"}, 32'(freqSelect), 32'(f));
    check({tag, "_lp"}, 32'(lowpassSelect), 32'(l));
    check({tag, "_hp"}, 32'(highpassSelect), 32'(h));
  endtask
  initial begin
    tick(3);
    check_sel("reset", 3'd5, 3'd0, 3'd0);
    check("reset_valid", 32'(cfgValid), 0);
    reset_n = 1'b1;
    tick(2);
    // 1: clean press of buttons[3], loader not ready
    buttons = 16'hFFF7;
    tick(7);
    check("t1_valid_before", 32'(cfgValid), 0);
    tick(1);
    check("t1_valid_edge7", 32'(cfgValid), 1);
    check("t1_freq", 32'(freqSelect), 3);
    tick(10);
    check("t1_valid_held", 32'(cfgValid), 1);
    cfgReady = 1'b1;
    tick(1);
    check("t1_valid_ack", 32'(cfgValid), 0);
    cfgReady = 1'b0;
    tick(2);
    buttons = 16'hFFFF;
    tick(10);
    // 2: bouncing press of buttons[9] with loader always ready
    cfgReady = 1'b1;
    buttons = 16'hFDFF;
    tick(2);
    buttons = 16'hFFFF;
    tick(1);
    buttons = 16'hFDFF;
    watch(25, n);
    check("t2_valid_cycles", 32'(n), 1);
    check_sel("t2", 3'd3, 3'd1, 3'd0);
    buttons = 16'hFFFF;
    tick(10);
    // 3: press that selects the current value gives no handshake
    cfgReady = 1'b0;
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    buttons = 16'hFFDF;
    watch(20, n);
    check("t3_valid_cycles", 32'(n), 0);
    check_sel("t3", 3'd5, 3'd0, 3'd0);
    check("t3_state_held", 32'(dut.state), 32'(WAIT_RELEASE));
    buttons = 16'hFFFF;
    tick(5);
    check("t3_state_before_idle", 32'(dut.state), 32'(WAIT_RELEASE));
    tick(1);
    check("t3_state_idle", 32'(dut.state), 32'(IDLE));
    tick(2);
    // 4: set highpass then chord restores defaults once
    cfgReady = 1'b1;
    buttons = 16'hBFFF;
    watch(15, n);
    check("t4_hp_set", 32'(highpassSelect), 2);
    buttons = 16'hFFFF;
    tick(10);
    buttons = 16'hEFFE;
    watch(15, n);
    check("t4_chord_valid", 32'(n), 1);
    check_sel("t4_chord", 3'd5, 3'd0, 3'd0);
    buttons = 16'hFFFF;
    tick(10);
    buttons = 16'hEFFE;
    watch(15, n);
    check("t4_chord_repeat_valid", 32'(n), 0);
    buttons = 16'hFFFF;
    tick(10);
    // 5: second button during WAIT_ACK and while held is ignored
    cfgReady = 1'b0;
    buttons = 16'hBFFF;
    tick(9);
    check("t5_valid", 32'(cfgValid), 1);
    buttons = 16'hBFFD;
    tick(5);
    check_sel("t5_wait", 3'd5, 3'd0, 3'd2);
    check("t5_valid_hold", 32'(cfgValid), 1);
    cfgReady = 1'b1;
    tick(1);
    check("t5_valid_ack", 32'(cfgValid), 0);
    cfgReady = 1'b0;
    watch(10, n);
    check("t5_both_held_valid", 32'(n), 0);
    buttons = 16'hFFFD;
    watch(12, n);
    check("t5_partial_release_valid", 32'(n), 0);
    check_sel("t5_end", 3'd5, 3'd0, 3'd2);
    buttons = 16'hFFFF;
    tick(10);
    // 6: reset during WAIT_ACK abandons the transfer
    buttons = 16'hFFFB;
    tick(9);
    check("t6_valid_pending", 32'(cfgValid), 1);
    check("t6_freq_pending", 32'(freqSelect), 2);
    reset_n = 1'b0;
    tick(1);
    check("t6_valid_reset", 32'(cfgValid), 0);
    check_sel("t6", 3'd5, 3'd0, 3'd0);
    check("t6_state", 32'(dut.state), 32'(IDLE));
    reset_n = 1'b1;
    buttons = 16'hFFFF;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
